serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/full_adder_nand.sv | 31 +++
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and constants for the bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_nand.sv
// ============================================================================
//  Module      : full_adder_nand
//  Description : One-bit full adder built purely from two-input NAND gates.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_nand (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_n1, w_n2, w_n3, w_x, w_n4, w_n5, w_n6;

    // First NAND-XOR stage forms a^b; the second folds in cin.
    assign w_n1 = ~(a & b);
    assign w_n2 = ~(a & w_n1);
    assign w_n3 = ~(b & w_n1);
    assign w_x  = ~(w_n2 & w_n3);
    assign w_n4 = ~(w_x & cin);
    assign w_n5 = ~(w_x & w_n4);
    assign w_n6 = ~(cin & w_n4);
    assign s    = ~(w_n5 & w_n6);
    assign cout = ~(w_n1 & w_n4);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder, LSB first, one full-adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_cout;
    logic             w_last;

    full_adder_nand u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_s_sr  <= {w_s, r_s_sr[WIDTH-1:1]};
            r_carry <= w_cout;
            // Counter parks at the last bit index instead of wrapping.
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_sum  <= {w_s, r_s_sr[WIDTH-1:1]};
                r_cout <= w_cout;
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start3 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic [2:0] a3 = '0, b3 = '0, sum3;
    logic       cin8 = 1'b0, cin3 = 1'b0;
    logic       busy8, done8, cout8, busy3, done3, cout3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: an add accepted at edge acc shows busy for WIDTH
    // edges, done on the next, and the next request is taken WIDTH+2 later.
    int k = 0;
    int wid[2] = '{8, 3};
    bit pend[2] = '{0, 0};
    int acc[2] = '{0, 0};
    int res[2] = '{0, 0};
    int held[2] = '{0, 0};
    int acc_n[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                pend[d] = 1'b0;
                held[d] = 0;
            end
        end else begin
            k++;
            for (int d = 0; d < 2; d++) begin
                logic st;
                st = (d == 0) ? start8 : start3;
                if (pend[d] && k == acc[d] + wid[d]) held[d] = res[d];
                if (st && (!pend[d] || k >= acc[d] + wid[d] + 2)) begin
                    pend[d] = 1'b1;
                    acc[d]  = k;
                    res[d]  = (d == 0) ? int'(a8) + int'(b8) + int'(cin8)
                                       : int'(a3) + int'(b3) + int'(cin3);
                    acc_n[d]++;
                end
            end
        end
    end

    int  cyc = 0;
    int  last_done = -1;
    bit  sp_on = 1'b0;

    always @(negedge clk) begin
        int eb[2];
        int ed[2];
        cyc++;
        for (int d = 0; d < 2; d++) begin
            eb[d] = (pend[d] && k >= acc[d] && k <= acc[d] + wid[d] - 1) ? 1 : 0;
            ed[d] = (pend[d] && k == acc[d] + wid[d]) ? 1 : 0;
        end
        check("busy8", int'(busy8), eb[0]);
        check("done8", int'(done8), ed[0]);
        check("sum8",  int'(sum8),  held[0] & 8'hFF);
        check("cout8", int'(cout8), (held[0] >> 8) & 1);
        check("busy3", int'(busy3), eb[1]);
        check("done3", int'(done3), ed[1]);
        check("sum3",  int'(sum3),  held[1] & 7);
        check("cout3", int'(cout3), (held[1] >> 3) & 1);
        if (done3) begin
            if (sp_on && last_done >= 0) check("spacing3", cyc - last_done, 5);
            last_done = cyc;
        end
    end

    // One WIDTH=8 add with literal expectations; ign_at>0 fires a stray
    // start that many cycles into the add, which must be ignored.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input int ign_at, input logic [7:0] es, input logic ec,
                        input string nm);
        int lat;
        int busyc;
        bit held_ok;
        logic [7:0] old;
        old = sum8;
        held_ok = 1'b1;
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb_; cin8 = tc;
        @(negedge clk);
        start8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
        lat = 0;
        busyc = 0;
        while (!done8 && lat < 20) begin
            if (busy8) busyc++;
            if (busy8 && sum8 != old) held_ok = 1'b0;
            @(negedge clk);
            lat++;
            if (ign_at > 0 && lat == ign_at) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check({nm, "_latency"}, lat, 8);
        check({nm, "_busycycles"}, busyc, 8);
        check({nm, "_hold"}, int'(held_ok), 1);
        check({nm, "_sum"}, int'(sum8), int'(es));
        check({nm, "_cout"}, int'(cout8), int'(ec));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int c0;
        int dn;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_sum",  int'(sum8),  0);
        check("rst_cout", int'(cout8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "ff_01");
        run8(8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1, "a5_5a");
        run8(8'h3C, 8'h42, 1'b0, 0, 8'h7E, 1'b0, "3c_42");
        run8(8'h01, 8'h01, 1'b0, 3, 8'h02, 1'b0, "ignored");
        run8(8'h3C, 8'h42, 1'b0, 0, 8'h7E, 1'b0, "pre_rst");

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            int         t;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            t = int'(ra) + int'(rb) + int'(rc);
            run8(ra, rb, rc, 0, t[7:0], t[8], "rand");
        end

        // Abort an add with reset partway through.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        check("abort_sum",  int'(sum8),  0);
        check("abort_cout", int'(cout8), 0);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8) dn++;
        end
        check("abort_nodone", dn, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, "post_rst");

        // WIDTH=3: every a, b, cin with start held high throughout.
        sp_on = 1'b1;
        last_done = -1;
        start3 = 1'b1;
        for (int idx = 0; idx < 128; idx++) begin
            {a3, b3, cin3} = 7'(idx);
            c0 = acc_n[1];
            n = 0;
            while (acc_n[1] == c0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) check("accept3_timeout", n, 5);
        end
        start3 = 1'b0;
        repeat (8) @(negedge clk);
        sp_on = 1'b0;
        check("last3_sum",  int'(sum3),  7);
        check("last3_cout", int'(cout3), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
